// File: rtl/debug_sequencer.sv
// debug_sequencer: debug-mode controller for the MIPS pipeline.
//
// Decodes single-byte commands from the UART receiver and gates the
// pipeline clock-enable: continuous run ('c'), single step ('s') or halt.
// A dump command ('d') streams PC, the register file and the enabled-cycle
// count to the UART transmitter, MSB first, one byte per tx_start/tx_done
// handshake.
//
// Optional feature macro: DEBUG_AUTODUMP_EN
//   defined   - a halt reached while running starts a dump automatically and
//               the frame ends in HALTED.
//   undefined - a halt reached while running goes straight to HALTED and
//               waits for 'd'.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   rx_data       in   [7:0] received command byte
//   rx_valid      in   one-cycle strobe qualifying rx_data
//   tx_data       out  [7:0] byte to transmit
//   tx_start      out  one-cycle strobe requesting transmission of tx_data
//   tx_done       in   one-cycle strobe, transmitter finished current byte
//   halt_flag_d   in   halt instruction reached write-back
//   pc_value      in   [LEN_DATA-1:0] current PC
//   dbg_reg_addr  out  [NUM_BITS-1:0] register-file debug read address
//   dbg_reg_data  in   [LEN_DATA-1:0] combinational read data
//   pipe_enable   out  pipeline clock-enable
//   busy          out  high in any state other than IDLE and HALTED
module debug_sequencer #(
  parameter int         LEN_DATA = 32,
  parameter int         NUM_BITS = 5,
  parameter int         NUM_REGS = 32,
  parameter logic [7:0] CMD_RUN  = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73,
  parameter logic [7:0] CMD_DUMP = 8'h64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_done,
  input  logic                halt_flag_d,
  input  logic [LEN_DATA-1:0] pc_value,
  output logic [NUM_BITS-1:0] dbg_reg_addr,
  input  logic [LEN_DATA-1:0] dbg_reg_data,
  output logic                pipe_enable,
  output logic                busy
);

  // Frame layout: word 0 = PC, words 1..NUM_REGS = r0..r(NUM_REGS-1),
  // last word = cycle count.
  localparam int NUM_BYTES = LEN_DATA / 8;
  localparam int NUM_WORDS = NUM_REGS + 2;
  localparam int WW        = $clog2(NUM_WORDS);
  localparam int BW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [WW-1:0] LAST_WORD  = WW'(NUM_WORDS - 1);
  localparam logic [WW-1:0] NUM_REGS_W = WW'(NUM_REGS);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALTED,
    S_DUMP_LOAD,
    S_DUMP_SEND,
    S_DUMP_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic                ret_halted_q, ret_halted_d;  // dump returns to HALTED
  logic [WW-1:0]       word_q, word_d;
  logic [BW-1:0]       byte_q, byte_d;
  logic [LEN_DATA-1:0] shift_q, shift_d;
  logic [LEN_DATA-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [NUM_BITS-1:0] addr_q, addr_d;
  logic                pe_q, pe_d;
  logic                busy_q, busy_d;

  // Counts cycles the pipeline actually advanced; sticks at all-ones.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (pe_q && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + LEN_DATA'(1);
  end

  always_comb begin
    state_d      = state_q;
    ret_halted_d = ret_halted_q;
    word_d       = word_q;
    byte_d       = byte_q;
    shift_d      = shift_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    addr_d       = addr_q;
    pe_d         = pe_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_RUN) begin
            state_d = S_RUN;
            pe_d    = 1'b1;
          end else if (rx_data == CMD_STEP) begin
            state_d = S_STEP;
            pe_d    = 1'b1;
          end else if (rx_data == CMD_DUMP) begin
            state_d      = S_DUMP_LOAD;
            ret_halted_d = 1'b0;
            word_d       = '0;
            byte_d       = '0;
            addr_d       = '0;
          end
        end
      end

      S_RUN: begin
        if (halt_flag_d) begin
          pe_d = 1'b0;
`ifdef DEBUG_AUTODUMP_EN
          state_d      = S_DUMP_LOAD;
          ret_halted_d = 1'b1;
          word_d       = '0;
          byte_d       = '0;
          addr_d       = '0;
`else
          state_d = S_HALTED;
`endif
        end
      end

      // pipe_enable was raised on entry; this is the single enabled cycle.
      // A step that lands on a halt never auto-dumps.
      S_STEP: begin
        pe_d    = 1'b0;
        state_d = halt_flag_d ? S_HALTED : S_IDLE;
      end

      S_HALTED: begin
        if (rx_valid && (rx_data == CMD_DUMP)) begin
          state_d      = S_DUMP_LOAD;
          ret_halted_d = 1'b1;
          word_d       = '0;
          byte_d       = '0;
          addr_d       = '0;
        end
      end

      // dbg_reg_addr was set when this word was selected, so the register
      // read data has had a full cycle to settle.
      S_DUMP_LOAD: begin
        if (word_q == '0)            shift_d = pc_value;
        else if (word_q == LAST_WORD) shift_d = cycle_cnt_q;
        else                          shift_d = dbg_reg_data;
        state_d = S_DUMP_SEND;
      end

      S_DUMP_SEND: begin
        tx_data_d  = shift_q[LEN_DATA-1 -: 8];
        shift_d    = shift_q << 8;
        tx_start_d = 1'b1;
        state_d    = S_DUMP_WAIT;
      end

      S_DUMP_WAIT: begin
        if (tx_done) begin
          if (byte_q == LAST_BYTE) begin
            byte_d = '0;
            if (word_q == LAST_WORD) begin
              word_d  = '0;
              addr_d  = '0;
              state_d = ret_halted_q ? S_HALTED : S_IDLE;
            end else begin
              word_d = word_q + WW'(1);
              // Next word w+1 reads register w; the count word needs no read.
              if (word_q < NUM_REGS_W) addr_d = NUM_BITS'(word_q);
              state_d = S_DUMP_LOAD;
            end
          end else begin
            byte_d  = byte_q + BW'(1);
            state_d = S_DUMP_SEND;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        pe_d    = 1'b0;
      end
    endcase

    busy_d = !((state_d == S_IDLE) || (state_d == S_HALTED));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ret_halted_q <= 1'b0;
      word_q       <= '0;
      byte_q       <= '0;
      shift_q      <= '0;
      cycle_cnt_q  <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      addr_q       <= '0;
      pe_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_halted_q <= ret_halted_d;
      word_q       <= word_d;
      byte_q       <= byte_d;
      shift_q      <= shift_d;
      cycle_cnt_q  <= cycle_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      addr_q       <= addr_d;
      pe_q         <= pe_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign dbg_reg_addr = addr_q;
  assign pipe_enable  = pe_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: directed scenarios plus randomized traffic,
// all checked every cycle against a mode/queue model of the sequencer.
module tb_debug_sequencer;
  localparam int NR     = 32;
  localparam int NBYTES = (NR + 2) * 4;
  localparam logic [7:0] C_RUN  = 8'h63;
  localparam logic [7:0] C_STEP = 8'h73;
  localparam logic [7:0] C_DUMP = 8'h64;
`ifdef DEBUG_AUTODUMP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, rx_valid, tx_start, tx_done, halt_flag_d, pipe_enable, busy;
  logic [7:0]  rx_data, tx_data;
  logic [31:0] pc_value, dbg_reg_data;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] regs [NR];

  assign dbg_reg_data = regs[dbg_reg_addr];
  always #5 clk = ~clk;

  debug_sequencer dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .halt_flag_d(halt_flag_d), .pc_value(pc_value),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .pipe_enable(pipe_enable), .busy(busy)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT, M_DUMP} mode_e;
  mode_e       m_mode;
  bit          m_pe, m_ret_halt, m_out;
  logic [31:0] m_cnt;
  logic [7:0]  q[$];
  logic [7:0]  cap [NBYTES];
  int          cap_n, m_gap;
  int          long_at = -1;
  bit          rnd_dly = 1'b0;
  int          spur_req = 0, spur_done = 0;

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) q.push_back(w[b*8 +: 8]);
  endtask

  task automatic start_dump(input bit from_halt);
    q.delete();
    push_word(pc_value);
    for (int i = 0; i < NR; i++) push_word(regs[i]);
    push_word(m_cnt);
    m_mode = M_DUMP; m_ret_halt = from_halt; m_out = 1'b0;
    cap_n = 0; m_gap = 0;
  endtask

  function automatic logic [31:0] word(input int k);
    return {cap[4*k], cap[4*k+1], cap[4*k+2], cap[4*k+3]};
  endfunction

  // Compare at negedge: outputs reflect the last posedge; inputs present now
  // are what the next posedge samples, so the model then steps forward.
  initial begin
    m_mode = M_IDLE; m_pe = 0; m_ret_halt = 0; m_out = 0; m_cnt = 0; cap_n = 0; m_gap = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_pipe_enable", 64'(pipe_enable), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_tx_start", 64'(tx_start), 64'(0));
        chk("rst_tx_data", 64'(tx_data), 64'(0));
        chk("rst_dbg_reg_addr", 64'(dbg_reg_addr), 64'(0));
        m_mode = M_IDLE; m_pe = 0; m_out = 0; m_cnt = 0; q.delete();
      end else begin
        chk("pipe_enable", 64'(pipe_enable), 64'(m_pe));
        chk("busy", 64'(busy), 64'(!(m_mode == M_IDLE || m_mode == M_HALT)));
        if (m_mode != M_DUMP || m_out || q.size() == 0) begin
          chk("tx_start_quiet", 64'(tx_start), 64'(0));
        end else if (tx_start) begin
          chk($sformatf("tx_byte[%0d]", cap_n), 64'(tx_data), 64'(q[0]));
          cap[cap_n] = tx_data;
          cap_n++;
          void'(q.pop_front());
          m_out = 1'b1;
          m_gap = 0;
        end else begin
          m_gap++;
          if (m_gap == 7) chk("tx_stall", 64'(tx_start), 64'(1));
        end
        // advance to the state after the coming posedge
        if (m_pe && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        case (m_mode)
          M_IDLE: if (rx_valid) begin
            if (rx_data == C_RUN)       begin m_mode = M_RUN;  m_pe = 1; end
            else if (rx_data == C_STEP) begin m_mode = M_STEP; m_pe = 1; end
            else if (rx_data == C_DUMP) start_dump(1'b0);
          end
          M_RUN: if (halt_flag_d) begin
            m_pe = 0;
            if (AUTO) start_dump(1'b1); else m_mode = M_HALT;
          end
          M_STEP: begin
            m_pe = 0;
            m_mode = halt_flag_d ? M_HALT : M_IDLE;
          end
          M_HALT: if (rx_valid && rx_data == C_DUMP) start_dump(1'b1);
          M_DUMP: if (tx_done && m_out) begin
            m_out = 1'b0;
            if (q.size() == 0) m_mode = m_ret_halt ? M_HALT : M_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- transmitter responder ----------------
  initial begin
    int rcnt;
    rcnt = 0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      tx_done = 1'b0;
      if (!reset) rcnt = 0;
      else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) tx_done = 1'b1;
      end else if (tx_start) begin
        rcnt = (cap_n == long_at) ? 1000 : (rnd_dly ? int'($urandom_range(1, 8)) : 5);
      end else if (spur_req != spur_done) begin
        tx_done = 1'b1;
        spur_done++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step_clk();
    @(posedge clk); #2;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step_clk();
    rx_valid = 1'b0;
  endtask

  task automatic wait_dump(input string nm, input int limit);
    int n;
    n = 0;
    while (m_mode == M_DUMP && n < limit) begin step_clk(); n++; end
    if (m_mode == M_DUMP) begin
      total++; bad++;
      $display("FAIL %s: frame still running after %0d cycles, expected completion", nm, n);
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; halt_flag_d = 1'b0;
    pc_value = 32'h0040_0020;
    for (int i = 0; i < NR; i++) regs[i] = i * 32'h0101_0101;
    repeat (3) step_clk();
    chk("reset_pipe_enable", 64'(pipe_enable), 64'(0));
    chk("reset_tx_start", 64'(tx_start), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    reset = 1'b1;
    step_clk();

    // spurious tx_done while idle must not start anything
    spur_req += 3;
    repeat (10) step_clk();
    chk("idle_after_spurious_busy", 64'(busy), 64'(0));

    // single step
    send_cmd(C_STEP);
    chk("step_pe_on", 64'(pipe_enable), 64'(1));
    chk("step_busy_on", 64'(busy), 64'(1));
    step_clk();
    chk("step_pe_off", 64'(pipe_enable), 64'(0));
    chk("step_busy_off", 64'(busy), 64'(0));

    // dump from IDLE with one byte held back 1000 cycles
    long_at = 20;
    send_cmd(C_DUMP);
    wait_dump("dump1", 3000);
    long_at = -1;
    chk("dump1_len", 64'(cap_n), 64'(136));
    chk("dump1_pc", 64'(word(0)), 64'(32'h0040_0020));
    chk("dump1_r0", 64'(word(1)), 64'(0));
    chk("dump1_r1", 64'(word(2)), 64'(32'h0101_0101));
    chk("dump1_cnt", 64'(word(NR + 1)), 64'(1));

    // run, halt 10 cycles later
    send_cmd(C_RUN);
    repeat (9) step_clk();
    halt_flag_d = 1'b1;
    step_clk();
    halt_flag_d = 1'b0;
    chk("halt_pe_off", 64'(pipe_enable), 64'(0));
    chk("halt_busy", 64'(busy), 64'(AUTO));
    if (AUTO) begin
      wait_dump("autodump", 3000);
      chk("autodump_len", 64'(cap_n), 64'(136));
      chk("autodump_cnt", 64'(word(NR + 1)), 64'(11));
    end else begin
      repeat (20) step_clk();
      chk("no_autodump_busy", 64'(busy), 64'(0));
    end
    send_cmd(C_STEP);
    repeat (3) step_clk();
    send_cmd(C_RUN);
    repeat (3) step_clk();
    chk("halted_ignores_cmds", 64'(pipe_enable), 64'(0));
    send_cmd(C_DUMP);
    wait_dump("dump_halted", 3000);
    chk("dump_halted_len", 64'(cap_n), 64'(136));
    chk("dump_halted_cnt", 64'(word(NR + 1)), 64'(11));
    send_cmd(C_STEP);
    chk("still_halted", 64'(pipe_enable), 64'(0));

    // reset at byte 50 of a dump
    send_cmd(C_DUMP);
    n = 0;
    while (!(tx_start === 1'b1 && cap_n == 49) && n < 2000) begin step_clk(); n++; end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL reach_byte50: byte 50 not seen after %0d cycles", n);
    end
    reset = 1'b0;
    #1;
    chk("midreset_tx_start", 64'(tx_start), 64'(0));
    chk("midreset_busy", 64'(busy), 64'(0));
    repeat (3) step_clk();
    reset = 1'b1;
    step_clk();
    send_cmd(C_DUMP);
    wait_dump("dump_after_reset", 3000);
    chk("dump_after_reset_len", 64'(cap_n), 64'(136));
    chk("dump_after_reset_pc", 64'(word(0)), 64'(32'h0040_0020));
    chk("dump_after_reset_cnt", 64'(word(NR + 1)), 64'(0));

    // randomized traffic
    rnd_dly = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      int r, k;
      rx_valid = 1'b0; halt_flag_d = 1'b0;
      r = $urandom_range(0, 999);
      if (r < ((m_mode == M_HALT) ? 15 : 2)) begin
        reset = 1'b0;
        step_clk(); step_clk();
        reset = 1'b1;
      end else begin
        if (m_mode != M_DUMP && $urandom_range(0, 19) == 0) begin
          pc_value = $urandom;
          regs[$urandom_range(0, NR - 1)] = $urandom;
        end
        if ($urandom_range(0, 19) == 0) halt_flag_d = 1'b1;
        if ($urandom_range(0, 14) == 0) begin
          k = $urandom_range(0, 9);
          rx_valid = 1'b1;
          rx_data = (k < 4) ? C_RUN : (k < 7) ? C_STEP : (k == 7) ? C_DUMP : 8'($urandom_range(0, 255));
        end
        if (m_mode == M_IDLE && $urandom_range(0, 49) == 0) spur_req++;
        step_clk();
      end
    end
    rx_valid = 1'b0; halt_flag_d = 1'b0;
    wait_dump("random_tail", 3000);
    repeat (5) step_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
